iguana_pad_ctrl: RTL and testbench
==================================

Name: iguana_pad_ctrl

Overview:
Register-configurable pad multiplexer between Cheshire peripheral functions and chip pads.
- Generalises the fixed OE-polarity flip at the Iguana top to NumPads pads, each selectable among NumFunc functions.
- Output-enable polarity is configurable per pad.
- A per-pad guard sequencer forces the pad to tristate for GuardCycles cycles on every function change, so two drivers never overlap.
- Sits between cheshire_soc peripheral IOs and the pad ring; configured via the external reg bus.

Parameters:
NumPads, 16, number of pads (1..32)
NumFunc, 4, functions per pad (2..16); function 0 is the reset function
GuardCycles, 4, tristate cycles inserted on a function change (0 legal)
OeActiveLowMask, '0, NumPads bits; bit p=1 means pad_oe_o[p] is active-low at the pad
reg_req_t, logic, reg bus request type (48-bit addr, 32-bit data)
reg_rsp_t, logic, reg bus response type

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous active-low reset
reg_req_i  in  reg_req_t  config request (valid, write, addr, wdata, wstrb)
reg_rsp_o  out  reg_rsp_t  config response (ready, rdata, error)
func_o_i  in  NumFunc x NumPads  per-function output data
func_oe_i  in  NumFunc x NumPads  per-function output enable, active-high
func_i_o  out  NumFunc x NumPads  pad input routed back to functions
pad_o  out  NumPads  pad output data
pad_oe_o  out  NumPads  pad output enable, polarity per OeActiveLowMask
pad_i  in  NumPads  pad input data
busy_o  out  1  OR of all pads not in IDLE

Behaviour:
- Single clock domain. rst_ni is synchronous and active-low.
- Reset values:
  - all sel = 0, all FSMs IDLE
  - pad_o = 0
  - pad_oe_o = OeActiveLowMask (every pad inactive)
  - busy_o = 0
  - reg_rsp_o.rdata = 0, error = 0
- Register map (word offsets):
  - 0x000 + 4*p: SEL[p], bits [$clog2(NumFunc)-1:0], RW
  - 0x100: STATUS, bit p = pad p not IDLE, RO
- Reg handshake:
  - ready = 1 always; the response is combinational in the same cycle.
  - error = 1 for: unmapped address; write to STATUS; write with sel >= NumFunc. Erroring writes change nothing.
  - wstrb[0] = 0 on a SEL write: no effect, no error.
  - Reads return the target sel, not the active sel.
- Datapath:
  - pad_o[p] and pad_oe_o[p] are registered, 1-cycle latency from func_o_i[active_sel][p] and func_oe_i[active_sel][p].
  - pad_oe_o[p] is XORed with OeActiveLowMask[p] before the register.
- func_i_o:
  - Combinational: func_i_o[f][p] = pad_i[p] when f == active_sel[p] and pad p is IDLE; otherwise 0.
- Per-pad FSM:
  - States: IDLE, DRAIN, SWITCH.
  - IDLE, accepted SEL write with new value != active_sel: target <= value, count <= GuardCycles, go to DRAIN. If GuardCycles == 0, go to SWITCH.
  - IDLE, SEL write equal to active_sel: no state change.
  - DRAIN: outputs forced inactive (oe inactive, pad_o = 0); count decrements; at 1 go to SWITCH.
  - SWITCH: active_sel <= target; go to IDLE. Outputs remain forced inactive this cycle.
- Timing:
  - Write accepted in cycle t with G = GuardCycles >= 1: pad_oe_o inactive in cycles t+2 .. t+G+1; new function visible from t+G+2.
  - G = 0: new function visible from t+2, with no guard gap.
- SEL write during DRAIN or SWITCH: target updated, count reloaded to GuardCycles, state goes to DRAIN. The guard restarts and the pad never shows the intermediate function.
  - Exception: the new value equals active_sel and the state is DRAIN. The drain still completes; the pad returns to the same function afterwards.
- Writes to different pads are independent; pads sequence concurrently.
- Reset mid-DRAIN: all pads return to IDLE with sel 0; outputs inactive at the next edge.

Decomposition:
- Package iguana_pad_pkg holds:
  - register offsets SelBaseOffset = 'h000 and StatusOffset = 'h100
  - the pad_state_e enum {IDLE, DRAIN, SWITCH}
  - a function that computes the sel width from NumFunc
- Sub-module iguana_pad_chan, one per pad via generate. It contains the FSM, guard counter, target and active sel registers, output mux and output registers.
- The top module holds only reg decode and response.

Test Plan:
- Reset, OeActiveLowMask = 16'h0003 -> pad_oe_o = 16'h0003, pad_o = 0, busy_o = 0; read SEL[5] -> rdata 0, error 0.
- Pad 2 on function 0; drive func_o_i[0][2] = 1, func_oe_i[0][2] = 1 at cycle 5 -> pad_o[2] = 1 and pad_oe_o[2] = 1 at cycle 6.
- G = 4; write SEL[2] = 3 in cycle 10 with func_oe_i[3][2] = 1 -> pad_oe_o[2] = 0 in cycles 12..15, = 1 from 16; busy_o high 11..15; func_i_o[3][2] follows pad_i[2] from cycle 16.
- Write SEL[2] = 1 at cycle 10, then SEL[2] = 2 at cycle 12 -> guard restarts; pad_oe_o[2] inactive 12..17; function 2 visible at 18; function 1 never visible.
- Write SEL[0] = 7 with NumFunc = 4 -> error = 1, SEL[0] unchanged. Write to 0x100 -> error = 1. Read 0x200 -> error = 1.
- Assert rst_ni low at cycle 13 during a drain -> at cycle 14 all sel = 0, pad_oe_o = OeActiveLowMask, busy_o = 0.

Source files
------------

// File: rtl/iguana_pad_pkg.sv
// Shared definitions for the Iguana pad multiplexer: register offsets, the
// per-pad sequencer state type, default reg bus types and sel-width helper.
package iguana_pad_pkg;

    localparam logic [47:0] SelBaseOffset = 48'h000;
    localparam logic [47:0] StatusOffset  = 48'h100;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWITCH
    } pad_state_e;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [47:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } pad_reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } pad_reg_rsp_t;

    function automatic int unsigned sel_width(input int unsigned num_func);
        return (num_func > 1) ? $clog2(num_func) : 1;
    endfunction

endpackage

// File: rtl/iguana_pad_chan.sv
// One pad channel: guard sequencer that tristates the pad across a function
// change, plus the registered output mux and the input return path.
module iguana_pad_chan
    import iguana_pad_pkg::*;
#(
    parameter int unsigned NumFunc     = 4,
    parameter int unsigned GuardCycles = 4,
    parameter int unsigned SelWidth    = sel_width(NumFunc),
    parameter bit          OeActiveLow = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [SelWidth-1:0] wr_sel,
    input  logic [NumFunc-1:0]  func_out,
    input  logic [NumFunc-1:0]  func_oe,
    output logic [NumFunc-1:0]  func_in,
    input  logic                pad_in,
    output logic                pad_out,
    output logic                pad_oe,
    output logic [SelWidth-1:0] target_sel,
    output logic                busy
);

    localparam int unsigned           CntWidth  = $clog2(GuardCycles + 2);
    localparam logic [CntWidth-1:0]   GuardLoad = CntWidth'(GuardCycles);
    localparam pad_state_e            LoadState = (GuardCycles == 0) ? SWITCH : DRAIN;

    pad_state_e          state;
    logic [SelWidth-1:0] active_sel;
    logic [SelWidth-1:0] target_q;
    logic [CntWidth-1:0] count;
    logic [SelWidth-1:0] mux_sel;
    logic                drive;

    // SWITCH already feeds the new function into the output register so it
    // appears right after the guard; a write landing in SWITCH keeps it dark.
    always_comb begin
        mux_sel = active_sel;
        drive   = 1'b0;
        case (state)
            IDLE: drive = 1'b1;
            SWITCH: begin
                mux_sel = target_q;
                drive   = !wr_en;
            end
            default: drive = 1'b0;
        endcase
    end

    always_comb begin
        func_in = '0;
        if (state == IDLE) begin
            func_in[active_sel] = pad_in;
        end
    end

    assign busy       = (state != IDLE);
    assign target_sel = target_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            active_sel <= '0;
            target_q   <= '0;
            count      <= '0;
            pad_out    <= 1'b0;
            pad_oe     <= OeActiveLow;
        end else begin
            pad_out <= drive & func_out[mux_sel];
            pad_oe  <= (drive & func_oe[mux_sel]) ^ OeActiveLow;
            case (state)
                IDLE: begin
                    if (wr_en && (wr_sel != active_sel)) begin
                        target_q <= wr_sel;
                        count    <= GuardLoad;
                        state    <= LoadState;
                    end
                end
                DRAIN: begin
                    if (wr_en) begin
                        target_q <= wr_sel;
                        count    <= GuardLoad;
                        state    <= LoadState;
                    end else if (count <= CntWidth'(1)) begin
                        state <= SWITCH;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                SWITCH: begin
                    if (wr_en) begin
                        target_q <= wr_sel;
                        count    <= GuardLoad;
                        state    <= LoadState;
                    end else begin
                        active_sel <= target_q;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/iguana_pad_ctrl.sv
// Register-configurable pad multiplexer: reg bus decode and response, with
// one guarded channel per pad.
module iguana_pad_ctrl
    import iguana_pad_pkg::*;
#(
    parameter int unsigned        NumPads         = 16,
    parameter int unsigned        NumFunc         = 4,
    parameter int unsigned        GuardCycles     = 4,
    parameter logic [NumPads-1:0] OeActiveLowMask = '0,
    parameter type                reg_req_t       = pad_reg_req_t,
    parameter type                reg_rsp_t       = pad_reg_rsp_t
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  reg_req_t                         reg_req_i,
    output reg_rsp_t                         reg_rsp_o,
    input  logic [NumFunc-1:0][NumPads-1:0]  func_o_i,
    input  logic [NumFunc-1:0][NumPads-1:0]  func_oe_i,
    output logic [NumFunc-1:0][NumPads-1:0]  func_i_o,
    output logic [NumPads-1:0]               pad_o,
    output logic [NumPads-1:0]               pad_oe_o,
    input  logic [NumPads-1:0]               pad_i,
    output logic                             busy_o
);

    localparam int unsigned SelWidth = sel_width(NumFunc);
    localparam int unsigned PadIdxW  = (NumPads > 1) ? $clog2(NumPads) : 1;
    localparam logic [47:0] SelSpan  = 48'(4 * NumPads);

    logic [47:0]         sel_off;
    logic                hit_sel;
    logic                hit_status;
    logic [PadIdxW-1:0]  pad_idx;
    logic                sel_we;
    logic [NumPads-1:0]  busy_vec;
    logic [SelWidth-1:0] target_sel [NumPads];

    // Addresses below the SEL base wrap to huge offsets and fall out of range.
    always_comb begin
        sel_off    = reg_req_i.addr - SelBaseOffset;
        hit_sel    = (sel_off < SelSpan) && (sel_off[1:0] == 2'b00);
        hit_status = (reg_req_i.addr == StatusOffset);
        pad_idx    = sel_off[PadIdxW+1:2];
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        sel_we          = 1'b0;
        if (reg_req_i.valid) begin
            if (hit_sel) begin
                if (reg_req_i.write) begin
                    if (reg_req_i.wstrb[0]) begin
                        if (reg_req_i.wdata >= 32'(NumFunc)) begin
                            reg_rsp_o.error = 1'b1;
                        end else begin
                            sel_we = 1'b1;
                        end
                    end
                end else begin
                    reg_rsp_o.rdata = 32'(target_sel[pad_idx]);
                end
            end else if (hit_status) begin
                if (reg_req_i.write) begin
                    reg_rsp_o.error = 1'b1;
                end else begin
                    reg_rsp_o.rdata = 32'(busy_vec);
                end
            end else begin
                reg_rsp_o.error = 1'b1;
            end
        end
    end

    assign busy_o = |busy_vec;

    for (genvar p = 0; p < NumPads; p++) begin : g_pad
        logic [NumFunc-1:0] chan_fo;
        logic [NumFunc-1:0] chan_foe;
        logic [NumFunc-1:0] chan_fi;

        for (genvar f = 0; f < NumFunc; f++) begin : g_func
            assign chan_fo[f]     = func_o_i[f][p];
            assign chan_foe[f]    = func_oe_i[f][p];
            assign func_i_o[f][p] = chan_fi[f];
        end

        iguana_pad_chan #(
            .NumFunc     (NumFunc),
            .GuardCycles (GuardCycles),
            .SelWidth    (SelWidth),
            .OeActiveLow (OeActiveLowMask[p])
        ) u_chan (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .wr_en      (sel_we && (pad_idx == PadIdxW'(p))),
            .wr_sel     (reg_req_i.wdata[SelWidth-1:0]),
            .func_out   (chan_fo),
            .func_oe    (chan_foe),
            .func_in    (chan_fi),
            .pad_in     (pad_i[p]),
            .pad_out    (pad_o[p]),
            .pad_oe     (pad_oe_o[p]),
            .target_sel (target_sel[p]),
            .busy       (busy_vec[p])
        );
    end

endmodule

// File: tb/tb_iguana_pad_ctrl.sv
// Self-checking bench for iguana_pad_ctrl: directed guard/error/reset cases
// followed by randomized traffic against a timestamp-based pad model.
module tb_iguana_pad_ctrl;
    import iguana_pad_pkg::*;

    localparam int          NP   = 16;
    localparam int          NF   = 4;
    localparam int          G    = 4;
    localparam logic [15:0] MASK = 16'h0003;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pad_reg_req_t            req;
    pad_reg_rsp_t            rsp;
    logic [NF-1:0][NP-1:0]   func_o;
    logic [NF-1:0][NP-1:0]   func_oe;
    logic [NF-1:0][NP-1:0]   func_i;
    logic [NP-1:0]           pad_o;
    logic [NP-1:0]           pad_oe;
    logic [NP-1:0]           pad_i;
    logic                    busy;

    iguana_pad_ctrl #(
        .NumPads         (NP),
        .NumFunc         (NF),
        .GuardCycles     (G),
        .OeActiveLowMask (MASK)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .reg_req_i (req),
        .reg_rsp_o (rsp),
        .func_o_i  (func_o),
        .func_oe_i (func_oe),
        .func_i_o  (func_i),
        .pad_o     (pad_o),
        .pad_oe_o  (pad_oe),
        .pad_i     (pad_i),
        .busy_o    (busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Pad model: a pending change has a dark window and a time it takes effect.
    int          cur [NP];
    int          tgt [NP];
    bit          pend [NP];
    int          gap_start [NP];
    int          gap_end [NP];
    int          done_at [NP];
    logic [63:0] prev_fo;
    logic [63:0] prev_foe;
    bit          after_reset = 1'b0;
    bit          model_valid = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic pad_reg_req_t mkReq(logic v, logic w, logic [47:0] a, logic [31:0] d, logic [3:0] s);
        pad_reg_req_t r;
        r.valid = v;
        r.write = w;
        r.addr  = a;
        r.wdata = d;
        r.wstrb = s;
        return r;
    endfunction

    function automatic int padOf(logic [47:0] a);
        for (int p = 0; p < NP; p++) begin
            if (a == 48'(4 * p)) return p;
        end
        return -1;
    endfunction

    task automatic runChecks();
        logic [15:0] exp_po;
        logic [15:0] exp_oe;
        logic [15:0] exp_busy;
        logic [63:0] exp_fi;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          p;
        int          f;
        for (int i = 0; i < NP; i++) begin
            if (pend[i] && cyc >= done_at[i]) begin
                cur[i]  = tgt[i];
                pend[i] = 1'b0;
            end
        end
        exp_po = '0;
        exp_oe = MASK;
        exp_busy = '0;
        exp_fi = '0;
        for (int i = 0; i < NP; i++) begin
            exp_busy[i] = pend[i];
            if (!pend[i]) exp_fi[cur[i] * 16 + i] = pad_i[i];
            if (!after_reset && !(pend[i] && cyc >= gap_start[i] && cyc <= gap_end[i])) begin
                f = cur[i];
                exp_po[i] = prev_fo[f * 16 + i];
                exp_oe[i] = prev_foe[f * 16 + i] ^ MASK[i];
            end
        end
        exp_err = 1'b0;
        exp_rdata = '0;
        if (req.valid) begin
            p = padOf(req.addr);
            if (p >= 0) begin
                if (req.write) exp_err = req.wstrb[0] && (req.wdata >= NF);
                else exp_rdata = 32'(pend[p] ? tgt[p] : cur[p]);
            end else if (req.addr == 48'h100) begin
                if (req.write) exp_err = 1'b1;
                else exp_rdata = 32'(exp_busy);
            end else begin
                exp_err = 1'b1;
            end
        end
        if (model_valid) begin
            checkOutput("pad_o", 64'(pad_o), 64'(exp_po));
            checkOutput("pad_oe", 64'(pad_oe), 64'(exp_oe));
            checkOutput("busy", 64'(busy), 64'(|exp_busy));
            checkOutput("func_i", func_i, exp_fi);
            checkOutput("ready", 64'(rsp.ready), 64'd1);
            checkOutput("error", 64'(rsp.error), 64'(exp_err));
            checkOutput("rdata", 64'(rsp.rdata), 64'(exp_rdata));
        end
    endtask

    task automatic updateModel();
        int p;
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                cur[i]  = 0;
                tgt[i]  = 0;
                pend[i] = 1'b0;
            end
            after_reset = 1'b1;
            model_valid = 1'b1;
        end else begin
            after_reset = 1'b0;
            p = padOf(req.addr);
            if (req.valid && req.write && p >= 0 && req.wstrb[0] && req.wdata < NF) begin
                if (pend[p] || int'(req.wdata) != cur[p]) begin
                    if (!pend[p]) gap_start[p] = cyc + 2;
                    pend[p]    = 1'b1;
                    tgt[p]     = int'(req.wdata);
                    gap_end[p] = cyc + G + 1;
                    done_at[p] = cyc + G + 2;
                end
            end
        end
        prev_fo  = func_o;
        prev_foe = func_oe;
        cyc++;
    endtask

    task automatic applyStimulus(input logic rstn, input pad_reg_req_t r, input logic [63:0] fo,
                                 input logic [63:0] foe, input logic [15:0] pi);
        @(posedge clk);
        #1;
        rst_n   = rstn;
        req     = r;
        func_o  = fo;
        func_oe = foe;
        pad_i   = pi;
        #1;
        runChecks();
        updateModel();
    endtask

    pad_reg_req_t idle;
    logic [6:0]   oe_log7;
    logic [6:0]   busy_log7;
    logic [6:0]   fi_log7;
    logic [8:0]   oe_log9;
    logic [8:0]   po_log9;

    initial begin
        idle = mkReq(1'b0, 1'b0, 48'h0, 32'h0, 4'h0);
        req = idle;
        func_o = '0;
        func_oe = '0;
        pad_i = '0;

        applyStimulus(1'b0, idle, 64'h0, 64'h0, 16'h0);
        applyStimulus(1'b0, idle, 64'h0, 64'h0, 16'h0);

        // Reset state and a read of SEL[5].
        applyStimulus(1'b1, mkReq(1'b1, 1'b0, 48'h14, 32'h0, 4'h0), 64'h0, 64'h0, 16'h0);
        checkOutput("rst_pad_oe", 64'(pad_oe), 64'h0003);
        checkOutput("rst_pad_o", 64'(pad_o), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_sel5", 64'(rsp.rdata), 64'h0);

        // Function 0 passes through with one cycle of latency.
        applyStimulus(1'b1, idle, {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
        applyStimulus(1'b1, idle, {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
        checkOutput("f0_pad_o2", 64'(pad_o[2]), 64'd1);
        checkOutput("f0_pad_oe2", 64'(pad_oe[2]), 64'd1);

        // SEL[2] = 3: four dark cycles, then function 3.
        applyStimulus(1'b1, mkReq(1'b1, 1'b1, 48'h8, 32'd3, 4'hF), {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, idle, {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
            oe_log7[k]   = pad_oe[2];
            busy_log7[k] = busy;
            fi_log7[k]   = func_i[3][2];
        end
        checkOutput("guard_oe", 64'(oe_log7), 64'(7'b1100001));
        checkOutput("guard_busy", 64'(busy_log7), 64'(7'b0011111));
        checkOutput("guard_func_i", 64'(fi_log7), 64'(7'b1100000));

        // SEL[2] = 1 then = 2 two cycles later: guard restarts, function 1 never shows.
        applyStimulus(1'b1, mkReq(1'b1, 1'b1, 48'h8, 32'd1, 4'hF),
                      64'hFFFF_FFFF_0000_FFFF, {64{1'b1}}, 16'hFFFF);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, (k == 1) ? mkReq(1'b1, 1'b1, 48'h8, 32'd2, 4'hF) : idle,
                          64'hFFFF_FFFF_0000_FFFF, {64{1'b1}}, 16'hFFFF);
            oe_log9[k] = pad_oe[2];
            po_log9[k] = pad_o[2];
        end
        checkOutput("restart_oe", 64'(oe_log9), 64'(9'b110000001));
        checkOutput("restart_pad_o", 64'(po_log9), 64'(9'b110000001));

        // Register error cases.
        applyStimulus(1'b1, mkReq(1'b1, 1'b1, 48'h0, 32'd7, 4'hF), 64'h0, 64'h0, 16'h0);
        checkOutput("err_sel_range", 64'(rsp.error), 64'd1);
        applyStimulus(1'b1, mkReq(1'b1, 1'b1, 48'h0, 32'd1, 4'h0), 64'h0, 64'h0, 16'h0);
        checkOutput("nostrb_error", 64'(rsp.error), 64'd0);
        applyStimulus(1'b1, mkReq(1'b1, 1'b0, 48'h0, 32'h0, 4'h0), 64'h0, 64'h0, 16'h0);
        checkOutput("sel0_unchanged", 64'(rsp.rdata), 64'd0);
        applyStimulus(1'b1, mkReq(1'b1, 1'b1, 48'h100, 32'h1, 4'hF), 64'h0, 64'h0, 16'h0);
        checkOutput("err_status_wr", 64'(rsp.error), 64'd1);
        applyStimulus(1'b1, mkReq(1'b1, 1'b0, 48'h200, 32'h0, 4'h0), 64'h0, 64'h0, 16'h0);
        checkOutput("err_unmapped", 64'(rsp.error), 64'd1);

        // Reset in the middle of a drain.
        applyStimulus(1'b1, mkReq(1'b1, 1'b1, 48'h10, 32'd1, 4'hF), {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
        applyStimulus(1'b1, idle, {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
        applyStimulus(1'b1, idle, {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
        checkOutput("drain_busy", 64'(busy), 64'd1);
        applyStimulus(1'b0, idle, {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
        applyStimulus(1'b1, mkReq(1'b1, 1'b0, 48'h10, 32'h0, 4'h0), {64{1'b1}}, {64{1'b1}}, 16'hFFFF);
        checkOutput("rstdrain_oe", 64'(pad_oe), 64'h0003);
        checkOutput("rstdrain_busy", 64'(busy), 64'd0);
        checkOutput("rstdrain_sel4", 64'(rsp.rdata), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic        rstn;
            logic [47:0] a;
            logic [31:0] d;
            int          r;
            rstn = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 9);
            if (r <= 5)      a = 48'(4 * $urandom_range(0, 3));
            else if (r == 6) a = 48'(4 * $urandom_range(0, 15));
            else if (r == 7) a = 48'h100;
            else             a = 48'($urandom_range(0, 'h140));
            d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
            applyStimulus(rstn,
                          mkReq(($urandom_range(0, 2) == 0), 1'($urandom), a, d,
                                ($urandom_range(0, 5) == 0) ? 4'hE : 4'hF),
                          {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
